// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken
// branch squashes, multi-cycle data-memory waits with a timeout watchdog,
// and a saturating count of cycles in which the PC was held.
module pipeline_hazard_controller #(
   parameter int REG_W       = 16,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rest,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             if_id_freeze,
   output logic             id_ex_freeze,
   output logic             ex_mem_freeze,
   output logic             mem_wb_freeze,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

   state_t     state, state_next;
   logic [7:0] wait_cnt, wait_next;
   logic       err_set;
   logic       hazard_en;
   logic       lu;

   // A load in EX feeding a source of the instruction in ID; register 0 is
   // hardwired and can never create a dependency.
   assign lu = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

   // Registered state: sequencer state, wait counter, sticky error, stall count.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         mem_error    <= 1'b0;
         stall_cycles <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         if (err_set)
            mem_error <= 1'b1;
         if (pc_freeze && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   // Next-state and Mealy freeze/flush decode; memory stalls take priority,
   // then branch squash, then the load-use bubble. Reset silences everything.
   always_comb begin
      state_next    = state;
      wait_next     = wait_cnt;
      err_set       = 1'b0;
      hazard_en     = 1'b0;
      pc_freeze     = 1'b0;
      if_id_freeze  = 1'b0;
      id_ex_freeze  = 1'b0;
      ex_mem_freeze = 1'b0;
      mem_wb_freeze = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_flush  = 1'b0;

      case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               pc_freeze     = 1'b1;
               if_id_freeze  = 1'b1;
               id_ex_freeze  = 1'b1;
               ex_mem_freeze = 1'b1;
               mem_wb_freeze = 1'b1;
               state_next    = MEM_WAIT;
               wait_next     = 8'd1;
            end else begin
               hazard_en = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               hazard_en  = 1'b1;
               state_next = RUN;
               wait_next  = 8'd0;
            end else if (wait_cnt < TIMEOUT_W) begin
               pc_freeze     = 1'b1;
               if_id_freeze  = 1'b1;
               id_ex_freeze  = 1'b1;
               ex_mem_freeze = 1'b1;
               mem_wb_freeze = 1'b1;
               wait_next     = wait_cnt + 8'd1;
            end else begin
               mem_wb_flush = 1'b1;
               err_set      = 1'b1;
               hazard_en    = 1'b1;
               state_next   = RUN;
               wait_next    = 8'd0;
            end
         end
         default: begin
            state_next = RUN;
            wait_next  = 8'd0;
         end
      endcase

      if (hazard_en) begin
         if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (lu) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_flush  = 1'b1;
         end
      end

      if (rest) begin
         pc_freeze     = 1'b0;
         if_id_freeze  = 1'b0;
         id_ex_freeze  = 1'b0;
         ex_mem_freeze = 1'b0;
         mem_wb_freeze = 1'b0;
         if_id_flush   = 1'b0;
         id_ex_flush   = 1'b0;
         mem_wb_flush  = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for the pipeline hazard controller: directed vector table, hand
// sequences for memory wait / timeout / async reset, and a random run
// against a behavioural model.
module tb_pipeline_hazard_controller;

   localparam int REG_W   = 16;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rest;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             ex_mem_read, branch_taken, mem_req, mem_ready;
   logic             pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze, mem_wb_freeze;
   logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [7:0]       dut_vec;

   int checks = 0;
   int errors = 0;

   // Behavioural model: length of the outstanding memory stall (0 = none),
   // sticky error flag and stall counter as plain integers.
   int m_wait_len;
   bit m_err;
   int m_stall;

   localparam logic [7:0] V_NONE   = 8'b0000_0000;
   localparam logic [7:0] V_LU     = 8'b1100_0010;
   localparam logic [7:0] V_BR     = 8'b0000_0110;
   localparam logic [7:0] V_FROZEN = 8'b1111_1000;
   localparam logic [7:0] V_TOUT   = 8'b0000_0001;

   typedef struct {
      string            name;
      logic [REG_W-1:0] rs, rt, rd;
      logic             mr, bt, mq, my;
      logic [7:0]       exp;
   } vec_t;

   vec_t tbl[8];

   assign dut_vec = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
                     mem_wb_freeze, if_id_flush, id_ex_flush, mem_wb_flush};

   pipeline_hazard_controller #(.REG_W(REG_W), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rest(rest), .id_rs(id_rs), .id_rt(id_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze),
      .if_id_freeze(if_id_freeze), .id_ex_freeze(id_ex_freeze),
      .ex_mem_freeze(ex_mem_freeze), .mem_wb_freeze(mem_wb_freeze),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush), .mem_error(mem_error),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // Pipeline action implied by branch/load-use rules alone.
   function automatic logic [7:0] hazard_action();
      bit dep;
      dep = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
      if (branch_taken) return V_BR;
      if (dep)          return V_LU;
      return V_NONE;
   endfunction

   function automatic logic [7:0] model_vec();
      if (rest) return V_NONE;
      if (m_wait_len == 0)
         return (mem_req && !mem_ready) ? V_FROZEN : hazard_action();
      if (mem_ready)            return hazard_action();
      if (m_wait_len < TIMEOUT) return V_FROZEN;
      return hazard_action() | V_TOUT;
   endfunction

   task automatic model_reset();
      m_wait_len = 0;
      m_err      = 0;
      m_stall    = 0;
   endtask

   task automatic model_clock();
      logic [7:0] v;
      if (rest) return;
      v = model_vec();
      if (v[7]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (m_wait_len == 0) begin
         if (mem_req && !mem_ready) m_wait_len = 1;
      end else if (mem_ready) begin
         m_wait_len = 0;
      end else if (m_wait_len < TIMEOUT) begin
         m_wait_len++;
      end else begin
         m_wait_len = 0;
         m_err      = 1;
      end
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs just after the edge, check outputs at the
   // falling edge, then advance the model across the rising edge.
   task automatic apply_stimulus(input string name, input logic rst_in,
                                 input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                 input logic mr, input logic [REG_W-1:0] rd,
                                 input logic bt, input logic mq, input logic my,
                                 input logic has_exp, input logic [7:0] exp);
      rest = rst_in; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rd = rd;
      branch_taken = bt; mem_req = mq; mem_ready = my;
      if (rst_in) model_reset();
      @(negedge clk);
      check_output({name, " vec/model"}, 32'(dut_vec), 32'(model_vec()));
      check_output({name, " mem_error"}, 32'(mem_error), 32'(m_err));
      check_output({name, " stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
      if (has_exp) check_output({name, " vec/const"}, 32'(dut_vec), 32'(exp));
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle(input string name, input logic has_exp, input logic [7:0] exp);
      apply_stimulus(name, 0, 1, 2, 0, 3, 0, 0, 0, has_exp, exp);
   endtask

   task automatic do_reset();
      apply_stimulus("reset", 1, 5, 5, 1, 5, 1, 1, 0, 1, V_NONE);
   endtask

   initial begin
      tbl[0] = '{"load_use_rs", 5, 9, 5, 1, 0, 0, 0, V_LU};
      tbl[1] = '{"zero_reg",    3, 0, 0, 1, 0, 0, 0, V_NONE};
      tbl[2] = '{"branch_lu",   5, 9, 5, 1, 1, 0, 0, V_BR};
      tbl[3] = '{"load_use_rt", 2, 7, 7, 1, 0, 0, 0, V_LU};
      tbl[4] = '{"no_load",     5, 5, 5, 0, 0, 0, 0, V_NONE};
      tbl[5] = '{"mem_hit",     1, 2, 3, 0, 0, 1, 1, V_NONE};
      tbl[6] = '{"hit_lu",      4, 4, 4, 1, 0, 1, 1, V_LU};
      tbl[7] = '{"no_match",    1, 2, 3, 1, 0, 0, 0, V_NONE};

      model_reset();
      rest = 1'b1; id_rs = 0; id_rt = 0; ex_mem_read = 0; ex_rd = 0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
      @(posedge clk); #1;
      do_reset();

      // Directed single-cycle vectors from RUN.
      for (int i = 0; i < 8; i++)
         apply_stimulus(tbl[i].name, 0, tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].rd,
                        tbl[i].bt, tbl[i].mq, tbl[i].my, 1, tbl[i].exp);
      check_output("stall_after_table", 32'(stall_cycles), 32'd3);

      // Slow memory: three frozen cycles then the ready cycle.
      do_reset();
      for (int i = 0; i < 3; i++)
         apply_stimulus("slow_wait", 0, 1, 2, 0, 3, 0, 1, 0, 1, V_FROZEN);
      apply_stimulus("slow_ready", 0, 1, 2, 0, 3, 0, 1, 1, 1, V_NONE);
      check_output("slow_stall_cnt", 32'(stall_cycles), 32'd3);
      idle("slow_after", 1, V_NONE);

      // Timeout: four frozen cycles, one flush cycle, then sticky error.
      do_reset();
      for (int i = 0; i < TIMEOUT; i++)
         apply_stimulus("tout_wait", 0, 1, 2, 0, 3, 0, 1, 0, 1, V_FROZEN);
      apply_stimulus("tout_flush", 0, 1, 2, 0, 3, 0, 1, 0, 1, V_TOUT);
      check_output("tout_err_set", 32'(mem_error), 32'd1);
      idle("tout_after", 1, V_NONE);
      check_output("tout_err_sticky", 32'(mem_error), 32'd1);

      // Async reset in the middle of a memory wait.
      do_reset();
      apply_stimulus("ar_wait0", 0, 1, 2, 0, 3, 0, 1, 0, 1, V_FROZEN);
      apply_stimulus("ar_wait1", 0, 1, 2, 0, 3, 0, 1, 0, 1, V_FROZEN);
      #2;
      check_output("ar_pre_frozen", 32'(dut_vec), 32'(V_FROZEN));
      rest = 1'b1;
      model_reset();
      #1;
      check_output("ar_vec_drop", 32'(dut_vec), 32'(V_NONE));
      check_output("ar_stall_clr", 32'(stall_cycles), 32'd0);
      check_output("ar_err_clr", 32'(mem_error), 32'd0);
      @(posedge clk); #1;
      apply_stimulus("ar_run_lu", 0, 6, 1, 1, 6, 0, 0, 0, 1, V_LU);

      // Randomised run against the model, with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         apply_stimulus("rand", ($urandom_range(0, 99) == 0),
                        REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), REG_W'($urandom_range(0, 3)),
                        ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 4),
                        ($urandom_range(0, 9) < 4), 0, V_NONE);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
